// File: rtl/count_sequencer.sv
// count_sequencer: command-side controller for a 16-bit up/down counter.
// Loads a preset, steps the counter toward a target in the requested direction
// and stops exactly on it, reporting step count, wrap count and the end reason.
// Ports: CLK/clear (async active-low reset); start/mode/preset/target command;
//   abort; A_count/oFlow from the counter; dataIn/load/up/down to the counter;
//   busy/done/hit/timeout/aborted/steps/wraps status.
module count_sequencer #(
  parameter logic [15:0] MAX_STEPS = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        clear,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] preset,
  input  logic [15:0] target,
  input  logic        abort,
  input  logic [15:0] A_count,
  input  logic        oFlow,
  output logic [15:0] dataIn,
  output logic        load,
  output logic        up,
  output logic        down,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic        timeout,
  output logic        aborted,
  output logic [15:0] steps,
  output logic [1:0]  wraps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q,   state_d;
  logic        mode_q,    mode_d;
  logic [15:0] preset_q,  preset_d;
  logic [15:0] target_q,  target_d;
  logic        hit_q,     hit_d;
  logic        timeout_q, timeout_d;
  logic        aborted_q, aborted_d;
  logic [15:0] steps_q,   steps_d;
  logic [1:0]  wraps_q,   wraps_d;

  logic at_target;
  logic budget_hit;
  logic step_en;

  // The count enable is decoded combinationally from the same exit
  // conditions the RUN state checks, so the counter is never stepped in the
  // cycle where it already sits on the target.
  always_comb begin
    at_target  = (A_count == target_q);
    budget_hit = (steps_q == MAX_STEPS);
    step_en    = (state_q == RUN) && !at_target && !abort && !budget_hit;
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      preset_q  <= 16'h0000;
      target_q  <= 16'h0000;
      hit_q     <= 1'b0;
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
      steps_q   <= 16'h0000;
      wraps_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      preset_q  <= preset_d;
      target_q  <= target_d;
      hit_q     <= hit_d;
      timeout_q <= timeout_d;
      aborted_q <= aborted_d;
      steps_q   <= steps_d;
      wraps_q   <= wraps_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    preset_d  = preset_q;
    target_d  = target_q;
    hit_d     = hit_q;
    timeout_d = timeout_q;
    aborted_d = aborted_q;
    steps_d   = steps_q;
    wraps_d   = wraps_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          mode_d    = mode;
          preset_d  = preset;
          target_d  = target;
          hit_d     = 1'b0;
          timeout_d = 1'b0;
          aborted_d = 1'b0;
          steps_d   = 16'h0000;
          wraps_d   = 2'd0;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        // Exit priority: target, then abort, then step budget.
        if (at_target) begin
          hit_d   = 1'b1;
          state_d = DONE;
        end else if (abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (budget_hit) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          steps_d = steps_q + 16'h0001;
        end
        // A wrap on the final step shows up in the compare cycle, which is
        // still RUN, so no wrap pulse is lost.
        if (oFlow && (wraps_q != 2'd3)) begin
          wraps_d = wraps_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    load    = (state_q == LOAD);
    up      = step_en && !mode_q;
    down    = step_en &&  mode_q;
    busy    = (state_q == LOAD) || (state_q == RUN);
    done    = (state_q == DONE);
    dataIn  = preset_q;
    hit     = hit_q;
    timeout = timeout_q;
    aborted = aborted_q;
    steps   = steps_q;
    wraps   = wraps_q;
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer with a behavioural up/down counter attached.
// Expected results per run come from the distance between preset and target,
// the step budget and the abort cycle, computed arithmetically.
module tb_count_sequencer;

  localparam int MAXS = 16;

  logic        CLK = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] preset = 16'h0;
  logic [15:0] target = 16'h0;
  logic [15:0] A_count;
  logic        oFlow;
  logic [15:0] dataIn;
  logic        load, up, down, busy, done, hit, timeout, aborted;
  logic [15:0] steps;
  logic [1:0]  wraps;

  count_sequencer #(.MAX_STEPS(16'(MAXS))) dut (
    .CLK(CLK), .clear(clear), .start(start), .mode(mode),
    .preset(preset), .target(target), .abort(abort),
    .A_count(A_count), .oFlow(oFlow),
    .dataIn(dataIn), .load(load), .up(up), .down(down),
    .busy(busy), .done(done), .hit(hit), .timeout(timeout),
    .aborted(aborted), .steps(steps), .wraps(wraps)
  );

  always #5 CLK = ~CLK;

  // Behavioural counter: load has priority, wrap pulse one cycle after wrap.
  logic [15:0] cnt_q = 16'h0;
  logic        ofl_q = 1'b0;
  always @(posedge CLK) begin
    if (load) begin
      cnt_q <= dataIn;
      ofl_q <= 1'b0;
    end else if (up) begin
      cnt_q <= cnt_q + 16'h1;
      ofl_q <= (cnt_q == 16'hFFFF);
    end else if (down) begin
      cnt_q <= cnt_q - 16'h1;
      ofl_q <= (cnt_q == 16'h0000);
    end else begin
      ofl_q <= 1'b0;
    end
  end
  assign A_count = cnt_q;
  assign oFlow   = ofl_q;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full run; ab_at = RUN cycle (1-based) in which abort is high, 0 = none.
  // spur = raise start with scrambled command inputs in the middle of the run.
  task automatic run(input logic [15:0] p, input logic [15:0] t, input logic m,
                     input int ab_at, input bit spur);
    logic [15:0] d, e16, fin;
    int k, e, n, upc, dnc, both, wexp;
    bit got_done, exp_hit, exp_ab, exp_to;
    d = m ? (p - t) : (t - p);
    k = int'(d);
    e = k;
    if (e > MAXS) e = MAXS;
    if (ab_at > 0 && (ab_at - 1) < e) e = ab_at - 1;
    exp_hit = (e == k);
    exp_ab  = !exp_hit && (ab_at > 0) && (ab_at - 1 == e);
    exp_to  = !exp_hit && !exp_ab;
    e16  = e[15:0];
    fin  = m ? (p - e16) : (p + e16);
    wexp = m ? int'(e > int'(p)) : int'(int'(p) + e > 65535);

    @(negedge CLK);
    start = 1'b1; mode = m; preset = p; target = t;
    @(posedge CLK);
    #1;
    start = 1'b0;
    n = 0; upc = 0; dnc = 0; both = 0; got_done = 1'b0;
    chk("load_cycle_load", load, 1'b1);
    chk("load_cycle_busy", busy, 1'b1);
    chk("load_cycle_data", dataIn, p);
    while (!got_done && n < 100) begin
      @(posedge CLK);
      n++;
      #1;
      abort = (ab_at > 0) && (n == ab_at);
      if (spur) begin
        start = (n == 2);
        if (n == 2) begin
          preset = 16'($urandom);
          target = 16'($urandom);
          mode   = ~m;
        end
      end
      #1;
      if (up) upc++;
      if (down) dnc++;
      if (up && down) both++;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
    chk("done_seen", got_done, 1'b1);
    chk("done_cycle", n, e + 2);
    chk("hit", hit, exp_hit);
    chk("aborted", aborted, exp_ab);
    chk("timeout", timeout, exp_to);
    chk("steps", steps, e16);
    chk("wraps", wraps, wexp);
    chk("a_count", A_count, fin);
    chk("up_cycles", upc, m ? 0 : e);
    chk("down_cycles", dnc, m ? e : 0);
    chk("up_down_both", both, 0);
    @(posedge CLK);
    #1;
    chk("done_pulse_len", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("steps_held", steps, e16);
    chk("hit_held", hit, exp_hit);
    chk("a_count_held", A_count, fin);
    chk("data_held", dataIn, p);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dataIn"}, dataIn, 16'h0);
    chk({tag, "_load"}, load, 1'b0);
    chk({tag, "_up"}, up, 1'b0);
    chk({tag, "_down"}, down, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_hit"}, hit, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_aborted"}, aborted, 1'b0);
    chk({tag, "_steps"}, steps, 16'h0);
    chk({tag, "_wraps"}, wraps, 2'd0);
  endtask

  initial begin
    logic [15:0] rp, rd, rt;
    logic        rm;
    int          rab;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge CLK);
    clear = 1'b1;

    // Directed runs.
    run(16'h0010, 16'h0015, 1'b0, 0, 1'b0);
    run(16'hFFFE, 16'h0001, 1'b0, 0, 1'b0);
    run(16'h0000, 16'hFFFD, 1'b1, 0, 1'b0);
    run(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
    run(16'h0000, 16'h1000, 1'b0, 5, 1'b0);

    // Abort while idle must leave results untouched.
    @(negedge CLK);
    abort = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_abort_busy", busy, 1'b0);
    chk("idle_abort_flag", aborted, 1'b1);
    chk("idle_abort_steps", steps, 16'd4);
    @(negedge CLK);
    abort = 1'b0;

    // Timeout with a start raised while busy.
    run(16'h0000, 16'd100, 1'b0, 0, 1'b1);
    // Target exactly at the budget still counts as a hit.
    run(16'h0100, 16'h0100 + 16'(MAXS), 1'b0, 0, 1'b0);

    // Reset in the middle of RUN, between clock edges.
    @(negedge CLK);
    start = 1'b1; mode = 1'b0; preset = 16'h0; target = 16'h1000;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #3;
    chk("pre_reset_up", up, 1'b1);
    clear = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    @(negedge CLK);
    clear = 1'b1;
    run(16'h0020, 16'h0022, 1'b0, 0, 1'b0);

    // Randomized runs.
    for (int i = 0; i < 24; i++) begin
      rp  = 16'($urandom);
      rd  = 16'($urandom_range(0, 24));
      rm  = 1'($urandom_range(0, 1));
      rt  = rm ? (rp - rd) : (rp + rd);
      rab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0;
      run(rp, rt, rm, rab, bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
